uart_pass_monitor: RTL and testbench

Harness-side UART sniffer that decodes the DUT's serial TX line (8N1) and drives the `success`/`failure` status consumed by the Arty100T test driver. It sits between the FPGA test harness UART pin and the driver's end-of-simulation logic. Software ends a test by printing a 4-byte pass or fail token; the monitor matches the token on the decoded byte stream and raises a sticky flag. Decoded bytes are also exported for logging.

---
 rtl/uart_pass_monitor.sv | 153 +++++++++++++++
 tb/tb_uart_pass_monitor.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_pass_monitor.sv
// uart_pass_monitor: 8N1 UART sniffer on the DUT TX line. It exports decoded
// bytes and raises a sticky success or failure flag when the last four good
// bytes match the pass or fail token.
module uart_pass_monitor #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter logic [31:0] PASS_WORD    = 32'h50415353,
  parameter logic [31:0] FAIL_WORD    = 32'h4641494C
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       uart_tx,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       success,
  output logic       failure,
  output logic [7:0] frame_err_count
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        state_q;
  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shreg_q;
  logic          rx_valid_q;
  logic [7:0]    rx_data_q;
  logic [31:0]   hist_q;
  logic          hist_upd_q;
  logic [7:0]    err_q;
  logic          success_q, failure_q;
  logic          rxs;

  assign rxs             = sync2_q;
  assign rx_valid        = rx_valid_q;
  assign rx_data         = rx_data_q;
  assign success         = success_q;
  assign failure         = failure_q;
  assign frame_err_count = err_q;

  // Two-flop synchronizer for the asynchronous TX line; idles high.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= uart_tx;
      sync2_q <= sync1_q;
    end
  end

  // Frame decoder: start-bit qualification, mid-bit sampling, stop check.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      hist_q     <= '0;
      hist_upd_q <= 1'b0;
      err_q      <= '0;
    end else begin
      rx_valid_q <= 1'b0;
      hist_upd_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!rxs) begin
            state_q <= S_START;
            cnt_q   <= '0;
          end
        end
        S_START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q <= '0;
            if (rxs) begin
              state_q <= S_IDLE;
            end else begin
              state_q   <= S_DATA;
              bit_idx_q <= '0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt_q == FULL_M1) begin
            cnt_q   <= '0;
            shreg_q <= {rxs, shreg_q[7:1]};
            if (bit_idx_q == 3'd7) begin
              state_q <= S_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt_q == FULL_M1) begin
            cnt_q <= '0;
            if (rxs) begin
              rx_valid_q <= 1'b1;
              rx_data_q  <= shreg_q;
              hist_q     <= {hist_q[23:0], shreg_q};
              hist_upd_q <= 1'b1;
              state_q    <= S_IDLE;
            end else begin
              if (err_q != 8'hFF) begin
                err_q <= err_q + 1'b1;
              end
              state_q <= S_BREAK;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_BREAK: begin
          if (rxs) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Sticky token match, only in the cycle after a history update; first flag wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      success_q <= 1'b0;
      failure_q <= 1'b0;
    end else if (hist_upd_q && !success_q && !failure_q) begin
      if (hist_q == PASS_WORD) begin
        success_q <= 1'b1;
      end else if (hist_q == FAIL_WORD) begin
        failure_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_pass_monitor.sv
// Self-checking bench for uart_pass_monitor: randomized and directed UART
// frames against a queue-based model of the expected byte stream and flags.
module tb_uart_pass_monitor;

  localparam int unsigned CPB = 16;
  localparam logic [31:0] PASS_W = 32'h50415353;
  localparam logic [31:0] FAIL_W = 32'h4641494C;
  localparam int LAT = 2 + 1 + CPB / 2 + 9 * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       uart_tx = 1'b1;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       success, failure;
  logic [7:0] frame_err_count;

  uart_pass_monitor #(
    .CLKS_PER_BIT(CPB),
    .PASS_WORD(PASS_W),
    .FAIL_WORD(FAIL_W)
  ) dut (
    .clock(clk),
    .reset(reset),
    .uart_tx(uart_tx),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .success(success),
    .failure(failure),
    .frame_err_count(frame_err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model state
  logic [7:0]  exp_q[$];
  int          start_q[$];
  logic [31:0] mhist;
  bit          es, ef, pend;
  int          merr;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    start_q.delete();
    mhist = '0;
    es = 1'b0;
    ef = 1'b0;
    pend = 1'b0;
    merr = 0;
  endtask

  // Compare process: flags every cycle, bytes/latency on each rx_valid.
  always @(negedge clk) begin
    if (!reset) begin
      if (pend) begin
        pend = 1'b0;
        if (!es && !ef) begin
          if (mhist == PASS_W) es = 1'b1;
          else if (mhist == FAIL_W) ef = 1'b1;
        end
      end
      check("success", {31'b0, success}, {31'b0, es});
      check("failure", {31'b0, failure}, {31'b0, ef});
      if (rx_valid) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_rx_valid: got data %0h expected no byte (cycle %0d)", rx_data, cyc);
        end else begin
          logic [7:0] b;
          int s, lat;
          b = exp_q.pop_front();
          s = start_q.pop_front();
          lat = cyc - s;
          check("rx_data", {24'b0, rx_data}, {24'b0, b});
          n_checks++;
          if (lat < LAT - 1 || lat > LAT + 1) begin
            n_fail++;
            $display("FAIL latency: got %0d expected %0d +/-1", lat, LAT);
          end
          mhist = {mhist[23:0], b};
          pend = 1'b1;
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    uart_tx = 1'b1;
    model_clear();
    wait_cyc(3);
    reset = 1'b0;
  endtask

  task automatic check_reset_vals();
    @(negedge clk);
    check("rst_rx_valid", {31'b0, rx_valid}, 32'd0);
    check("rst_rx_data", {24'b0, rx_data}, 32'd0);
    check("rst_success", {31'b0, success}, 32'd0);
    check("rst_failure", {31'b0, failure}, 32'd0);
    check("rst_err", {24'b0, frame_err_count}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit good);
    if (good) begin
      exp_q.push_back(b);
      start_q.push_back(cyc);
    end
    uart_tx = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_tx = b[i];
      wait_cyc(CPB);
    end
    uart_tx = good;
    wait_cyc(CPB);
    if (!good) begin
      if (merr < 255) merr++;
      uart_tx = 1'b1;
      wait_cyc(CPB);
    end
    check("frame_err_count", {24'b0, frame_err_count}, merr);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_frame(w[i*8 +: 8], 1'b1);
  endtask

  initial begin
    model_clear();
    do_reset();
    check_reset_vals();

    // Basic bytes
    send_frame(8'h55, 1'b1);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_cyc(CPB);

    // Randomized traffic
    for (int k = 0; k < 40; k++) begin
      logic [7:0] rb;
      bit gd;
      rb = 8'($urandom);
      gd = ($urandom_range(7) != 0);
      send_frame(rb, gd);
      wait_cyc($urandom_range(0, 2 * CPB));
    end
    wait_cyc(2 * CPB);

    // "xPASS" then "FAIL"
    do_reset();
    check_reset_vals();
    send_frame(8'h78, 1'b1);
    send_word(PASS_W);
    check("pin_pass_success", {31'b0, success}, 32'd1);
    check("pin_pass_failure", {31'b0, failure}, 32'd0);
    send_word(FAIL_W);
    check("pin_after_fail_success", {31'b0, success}, 32'd1);
    check("pin_after_fail_failure", {31'b0, failure}, 32'd0);

    // "FA", bad frame, "IL"
    do_reset();
    check_reset_vals();
    send_frame(8'h46, 1'b1);
    send_frame(8'h41, 1'b1);
    send_frame(8'h3C, 1'b0);
    send_frame(8'h49, 1'b1);
    send_frame(8'h4C, 1'b1);
    check("pin_fail_err", {24'b0, frame_err_count}, 32'd1);
    check("pin_fail_failure", {31'b0, failure}, 32'd1);
    check("pin_fail_success", {31'b0, success}, 32'd0);

    // Glitch: no byte, no error
    uart_tx = 1'b0;
    wait_cyc(4);
    uart_tx = 1'b1;
    wait_cyc(3 * CPB);
    check("glitch_err", {24'b0, frame_err_count}, merr);
    check("pin_glitch_err", {24'b0, frame_err_count}, 32'd1);

    // Break: 20 bit times low gives exactly one error
    uart_tx = 1'b0;
    wait_cyc(20 * CPB);
    merr++;
    uart_tx = 1'b1;
    wait_cyc(2 * CPB);
    check("break_err", {24'b0, frame_err_count}, merr);
    check("pin_break_err", {24'b0, frame_err_count}, 32'd2);
    send_frame(8'hA5, 1'b1);

    // Saturation
    for (int k = 0; k < 300; k++) send_frame(8'($urandom), 1'b0);
    check("pin_err_sat", {24'b0, frame_err_count}, 32'd255);

    // Reset mid-byte during "PAS", then "PASS"
    send_frame(8'h50, 1'b1);
    send_frame(8'h41, 1'b1);
    uart_tx = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 3; i++) begin
      uart_tx = ((8'h53 >> i) & 8'h01) != 0;
      wait_cyc(CPB);
    end
    do_reset();
    check_reset_vals();
    wait_cyc(12 * CPB);
    check("post_reset_quiet_err", {24'b0, frame_err_count}, 32'd0);
    send_word(PASS_W);
    check("pin_reset_pass", {31'b0, success}, 32'd1);

    // Drain outstanding expectations with a bound
    begin
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 1000) begin
        wait_cyc(1);
        t++;
      end
      check("drain_queue_empty", exp_q.size(), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
